// File: rtl/img_pkg.sv
// Shared image geometry defaults for the line buffer and the 3x3 morphology stages.
// Pixels are treated as opaque words; nothing here does arithmetic on pixel data.
package img_pkg;

  localparam int unsigned DefPicWidth  = 250;
  localparam int unsigned DefPicHeight = 250;
  localparam int unsigned DefPixWidth  = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

endpackage

// File: rtl/linebuf_ram.sv
// One image row of storage: single clock, one port, combinational read of the old word
// at addr while the new word is written at the clock edge (read-before-write).
module linebuf_ram #(
  parameter int unsigned DEPTH = 250,
  parameter int unsigned WIDTH = 24,
  parameter int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/matrix_linebuf_3row.sv
// Three-row column aligner: emits the pixel at (r-2,c), (r-1,c) and (r,c) for every
// input pixel from row 2 on, one cycle after it arrives.
module matrix_linebuf_3row
  import img_pkg::*;
#(
  parameter int unsigned PIC_WIDTH  = DefPicWidth,
  parameter int unsigned PIC_HEIGHT = DefPicHeight,
  parameter int unsigned WIDTH      = DefPixWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             eol_out
);

  localparam int unsigned ColW = $clog2(PIC_WIDTH);
  localparam int unsigned RowW = $clog2(PIC_HEIGHT);

  logic [ColW-1:0] col_q, col_d, pix_col;
  logic [RowW-1:0] row_q, row_d, pix_row;
  logic            last_col, last_row, row_ok;
  logic            ram_we;
  logic [WIDTH-1:0] rd_a, rd_b;

  // A sof pixel is position (0,0) regardless of where the counters were.
  always_comb begin
    pix_col  = sof ? '0 : col_q;
    pix_row  = sof ? '0 : row_q;
    last_col = (pix_col == ColW'(PIC_WIDTH - 1));
    last_row = (pix_row == RowW'(PIC_HEIGHT - 1));
    row_ok   = (pix_row >= RowW'(2));
    col_d    = last_col ? '0 : pix_col + ColW'(1);
    row_d    = pix_row;
    if (last_col) begin
      row_d = last_row ? '0 : pix_row + RowW'(1);
    end
  end

  assign ram_we = valid_in & ~rst;

  // ram_a holds row r-1; its displaced word shifts down into ram_b as row r-2.
  linebuf_ram #(
    .DEPTH (PIC_WIDTH),
    .WIDTH (WIDTH),
    .AddrW (ColW)
  ) u_ram_a (
    .clk   (clk),
    .we    (ram_we),
    .addr  (pix_col),
    .wdata (din),
    .rdata (rd_a)
  );

  linebuf_ram #(
    .DEPTH (PIC_WIDTH),
    .WIDTH (WIDTH),
    .AddrW (ColW)
  ) u_ram_b (
    .clk   (clk),
    .we    (ram_we),
    .addr  (pix_col),
    .wdata (rd_a),
    .rdata (rd_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      valid_out <= 1'b0;
      eol_out   <= 1'b0;
      dout1     <= '0;
      dout2     <= '0;
      dout3     <= '0;
    end else if (valid_in) begin
      col_q     <= col_d;
      row_q     <= row_d;
      valid_out <= row_ok;
      eol_out   <= row_ok & last_col;
      dout1     <= rd_b;
      dout2     <= rd_a;
      dout3     <= din;
    end else begin
      valid_out <= 1'b0;
      eol_out   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_linebuf_3row.sv
// Bench for matrix_linebuf_3row on a 4x4 frame: directed frame scenarios plus random
// traffic, all checked each cycle against a row/column image model.
module tb_matrix_linebuf_3row;

  localparam int PW = 4;
  localparam int PH = 4;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sof = 1'b0;
  logic         valid_in = 1'b0;
  logic [W-1:0] din = '0;
  logic         valid_out, eol_out;
  logic [W-1:0] dout1, dout2, dout3;

  matrix_linebuf_3row #(
    .PIC_WIDTH  (PW),
    .PIC_HEIGHT (PH),
    .WIDTH      (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sof       (sof),
    .valid_in  (valid_in),
    .din       (din),
    .valid_out (valid_out),
    .dout1     (dout1),
    .dout2     (dout2),
    .dout3     (dout3),
    .eol_out   (eol_out)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: current frame image and raster position.
  logic [W-1:0] img [PH][PW];
  int           mr = 0;
  int           mc = 0;
  logic         e_vo = 1'b0;
  logic         e_eol = 1'b0;
  logic [W-1:0] e_d1 = '0, e_d2 = '0, e_d3 = '0;
  logic         d12_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic v, input logic s, input logic r, input logic [W-1:0] d);
    if (r) begin
      mr = 0; mc = 0;
      e_vo = 0; e_eol = 0;
      e_d1 = '0; e_d2 = '0; e_d3 = '0;
      d12_known = 1'b1;
    end else if (v) begin
      if (s) begin
        mr = 0; mc = 0;
      end
      e_d3 = d;
      if (mr >= 2) begin
        e_vo = 1'b1;
        e_d1 = img[mr-2][mc];
        e_d2 = img[mr-1][mc];
        d12_known = 1'b1;
      end else begin
        e_vo = 1'b0;
        d12_known = 1'b0;
      end
      e_eol = e_vo && (mc == PW - 1);
      img[mr][mc] = d;
      mc++;
      if (mc == PW) begin
        mc = 0;
        mr = (mr + 1) % PH;
      end
    end else begin
      e_vo = 1'b0;
      e_eol = 1'b0;
    end
  endtask

  task automatic cycle(input logic v, input logic s, input logic r, input logic [W-1:0] d);
    valid_in = v; sof = s; rst = r; din = d;
    @(posedge clk);
    #1;
    model_step(v, s, r, d);
    check("valid_out", 32'(valid_out), 32'(e_vo));
    check("eol_out", 32'(eol_out), 32'(e_eol));
    check("dout3", 32'(dout3), 32'(e_d3));
    if (d12_known) begin
      check("dout1", 32'(dout1), 32'(e_d1));
      check("dout2", 32'(dout2), 32'(e_d2));
    end
  endtask

  function automatic logic [W-1:0] px(input int r, input int c);
    return W'(16 * r + c);
  endfunction

  task automatic pix(input int r, input int c, input logic s);
    cycle(1'b1, s, 1'b0, px(r, c));
  endtask

  initial begin
    for (int r = 0; r < PH; r++)
      for (int c = 0; c < PW; c++)
        img[r][c] = '0;

    cycle(1'b0, 1'b0, 1'b1, '0);
    check("reset_vo", 32'(valid_out), 32'd0);
    check("reset_d1", 32'(dout1), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);

    // Continuous frame
    for (int r = 0; r < PH; r++)
      for (int c = 0; c < PW; c++) begin
        pix(r, c, (r == 0 && c == 0));
        if (r == 2 && c == 1) begin
          check("cont_r2c1_d1", 32'(dout1), 32'h01);
          check("cont_r2c1_d2", 32'(dout2), 32'h11);
          check("cont_r2c1_d3", 32'(dout3), 32'h21);
        end
        if (r == 3 && c == 3) begin
          check("cont_r3c3_d1", 32'(dout1), 32'h13);
          check("cont_r3c3_d3", 32'(dout3), 32'h33);
          check("cont_r3c3_eol", 32'(eol_out), 32'd1);
        end
      end

    // Gapped frame: every pixel followed by an idle cycle
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < PW; c++) begin
        pix(r, c, (r == 0 && c == 0));
        if (r == 2 && c == 1) begin
          check("gap_r2c1_d1", 32'(dout1), 32'h01);
          check("gap_r2c1_d2", 32'(dout2), 32'h11);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'hee);
        check("gap_idle_vo", 32'(valid_out), 32'd0);
      end

    // Mid-frame sof at row 3 col 1
    for (int r = 0; r < PH; r++) pix(r, 0, (r == 0));
    for (int r = 0; r < 3; r++)
      for (int c = 1; c < PW; c++) pix(r, c, 1'b0);
    pix(0, 0, 1'b1);
    for (int i = 1; i < 12; i++) pix(i / PW, i % PW, 1'b0);
    check("resof_r2c3_d1", 32'(dout1), 32'h03);

    // Two frames back to back with one sof
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < PH; r++)
        for (int c = 0; c < PW; c++) begin
          pix(r, c, (f == 0 && r == 0 && c == 0));
          if (f == 1 && r < 2) check("f2_supp_vo", 32'(valid_out), 32'd0);
          if (f == 1 && r == 2 && c == 0) begin
            check("f2_r2c0_d1", 32'(dout1), 32'h00);
            check("f2_r2c0_d2", 32'(dout2), 32'h10);
            check("f2_r2c0_d3", 32'(dout3), 32'h20);
          end
        end

    // Reset mid-frame at row 2 col 2
    for (int i = 0; i < 11; i++) pix(i / PW, i % PW, (i == 0));
    cycle(1'b0, 1'b0, 1'b1, '0);
    check("rst_mid_d2", 32'(dout2), 32'd0);
    check("rst_mid_d3", 32'(dout3), 32'd0);
    for (int i = 0; i < 12; i++) begin
      pix(i / PW, i % PW, 1'b0);
      if (i < 8) check("rst_supp_vo", 32'(valid_out), 32'd0);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic v, s, r;
      v = ($urandom_range(99) < 70);
      s = ($urandom_range(99) < 3);
      r = ($urandom_range(199) == 0);
      cycle(v, s, r, W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
